// File: rtl/pim_addr_sequencer.sv
// Command-driven sequencer that drives the load strobes of the PIM source-address
// register and issues one element per cycle to the array datapath.
module pim_addr_sequencer #(
   parameter int N     = 10,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [N-1:0]     cmd_base,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             array_stall,
   input  logic             abort,
   output logic [N-1:0]     src_d,
   output logic [N-1:0]     src_mov_in,
   output logic             pim_load,
   output logic             mov_load,
   output logic             update_load,
   output logic             elem_valid,
   output logic [N-1:0]     cur_addr,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      STEP = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam logic [1:0] OP_VEC = 2'b00;
   localparam logic [1:0] OP_MOV = 2'b01;
   localparam logic [1:0] OP_SET = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   state_e             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [N-1:0]       base_q, base_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic [N-1:0]       cur_addr_q, cur_addr_d;
   logic               cmd_ready_q, cmd_ready_d;
   logic               step_go;

   // An element is accepted only when neither abort nor stall blocks it this cycle.
   assign step_go = (state_q == STEP) && !abort && !array_stall;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      base_d     = base_q;
      rem_d      = rem_q;
      cur_addr_d = cur_addr_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               op_d    = cmd_op;
               base_d  = cmd_base;
               rem_d   = cmd_len;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (op_q != OP_RSV) begin
               cur_addr_d = base_q;
            end
            if ((op_q == OP_SET) || (op_q == OP_RSV) || (rem_q == '0)) begin
               state_d = DONE;
            end else begin
               state_d = STEP;
            end
         end
         STEP: begin
            if (abort) begin
               state_d = DONE;
            end else if (!array_stall) begin
               cur_addr_d = cur_addr_q + N'(1);
               rem_d      = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Registered so ready stays low through reset and rises one clock after release.
      cmd_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= OP_VEC;
         base_q      <= '0;
         rem_q       <= '0;
         cur_addr_q  <= '0;
         cmd_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         base_q      <= base_d;
         rem_q       <= rem_d;
         cur_addr_q  <= cur_addr_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

   assign pim_load    = (state_q == LOAD) && ((op_q == OP_VEC) || (op_q == OP_SET));
   assign mov_load    = (state_q == LOAD) && (op_q == OP_MOV);
   assign src_d       = pim_load ? base_q : '0;
   assign src_mov_in  = mov_load ? base_q : '0;
   assign elem_valid  = step_go;
   assign update_load = step_go;
   assign cur_addr    = cur_addr_q;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign cmd_ready   = cmd_ready_q;

endmodule

// File: tb/tb_pim_addr_sequencer.sv
// Directed self-checking bench for pim_addr_sequencer: load strobes, element
// stepping with wrap, stalls, abort, zero-length/SET/reserved commands and reset.
module tb_pim_addr_sequencer;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [9:0] cmd_base;
   logic [7:0] cmd_len;
   logic       array_stall;
   logic       abort;
   logic [9:0] src_d;
   logic [9:0] src_mov_in;
   logic       pim_load;
   logic       mov_load;
   logic       update_load;
   logic       elem_valid;
   logic [9:0] cur_addr;
   logic       busy;
   logic       done;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int elem_cnt;
   int hs_a, hs_b;

   pim_addr_sequencer #(.N(10), .LEN_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_base    (cmd_base),
      .cmd_len     (cmd_len),
      .array_stall (array_stall),
      .abort       (abort),
      .src_d       (src_d),
      .src_mov_in  (src_mov_in),
      .pim_load    (pim_load),
      .mov_load    (mov_load),
      .update_load (update_load),
      .elem_valid  (elem_valid),
      .cur_addr    (cur_addr),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled mid-cycle on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Presents a command for one cycle; returns with the DUT in LOAD.
   task automatic apply_cmd(input logic [1:0] op, input logic [9:0] base, input logic [7:0] len,
                            output int hs_cyc);
      check_output("ready_before_cmd", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_base  = base;
      cmd_len   = len;
      hs_cyc    = cyc;
      step();
      cmd_valid = 1'b0;
      cmd_base  = 10'h155;
      cmd_len   = 8'hAA;
   endtask

   task automatic run_elems(input logic [9:0] base, input int n);
      logic [9:0] a;
      for (int i = 0; i < n; i++) begin
         a = base + i[9:0];
         check_output("elem_valid", elem_valid, 1);
         check_output("update_load", update_load, 1);
         check_output("elem_addr", cur_addr, a);
         check_output("no_load_in_step", pim_load | mov_load, 0);
         if (elem_valid) elem_cnt++;
         step();
      end
   endtask

   task automatic check_done(input logic [9:0] final_addr);
      check_output("done_pulse", done, 1);
      check_output("done_busy", busy, 1);
      check_output("done_ready", cmd_ready, 0);
      check_output("done_elem", elem_valid, 0);
      check_output("done_addr", cur_addr, final_addr);
      step();
      check_output("done_one_cycle", done, 0);
      check_output("idle_ready", cmd_ready, 1);
      check_output("idle_busy", busy, 0);
   endtask

   initial begin
      rst_n       = 1'b0;
      cmd_valid   = 1'b0;
      cmd_op      = 2'b00;
      cmd_base    = '0;
      cmd_len     = '0;
      array_stall = 1'b0;
      abort       = 1'b0;
      $display("[TB] start");

      // Reset state.
      repeat (2) @(negedge clk);
      check_output("rst_ready", cmd_ready, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_strobes", {pim_load, mov_load, update_load, elem_valid, done}, 0);
      check_output("rst_addr", cur_addr, 0);
      rst_n = 1'b1;
      #1;
      check_output("ready_low_at_release", cmd_ready, 0);
      step();
      check_output("ready_after_release", cmd_ready, 1);

      // 1) VEC base 0x010 len 4.
      apply_cmd(2'b00, 10'h010, 8'd4, hs_a);
      check_output("vec_pim_load", pim_load, 1);
      check_output("vec_src_d", src_d, 10'h010);
      check_output("vec_mov_load", mov_load, 0);
      check_output("vec_load_elem", elem_valid, 0);
      check_output("vec_load_busy", busy, 1);
      step();
      elem_cnt = 0;
      run_elems(10'h010, 4);
      check_output("vec_elem_count", elem_cnt, 4);
      check_done(10'h014);

      // 2) MOV with address wrap.
      apply_cmd(2'b01, 10'h3FE, 8'd3, hs_a);
      check_output("mov_mov_load", mov_load, 1);
      check_output("mov_src", src_mov_in, 10'h3FE);
      check_output("mov_pim_load", pim_load, 0);
      step();
      run_elems(10'h3FE, 3);
      check_done(10'h001);

      // 3) VEC len 5 with stall on STEP cycles 2-3.
      apply_cmd(2'b00, 10'h100, 8'd5, hs_a);
      step();
      elem_cnt = 0;
      run_elems(10'h100, 1);
      array_stall = 1'b1;
      for (int s = 0; s < 2; s++) begin
         #1;
         check_output("stall_elem", elem_valid, 0);
         check_output("stall_update", update_load, 0);
         check_output("stall_addr", cur_addr, 10'h101);
         check_output("stall_busy", busy, 1);
         step();
      end
      array_stall = 1'b0;
      #1;
      run_elems(10'h101, 4);
      check_output("stall_elem_count", elem_cnt, 5);
      check_output("stall_done_latency", cyc - hs_a, 9);
      check_done(10'h105);

      // 4) SET, then back-to-back VEC len 0, then reserved op.
      apply_cmd(2'b10, 10'h123, 8'd7, hs_a);
      check_output("set_pim_load", pim_load, 1);
      check_output("set_src_d", src_d, 10'h123);
      step();
      check_done(10'h123);
      apply_cmd(2'b00, 10'h050, 8'd0, hs_b);
      check_output("cmd_spacing", hs_b - hs_a, 3);
      check_output("len0_pim_load", pim_load, 1);
      check_output("len0_src_d", src_d, 10'h050);
      step();
      check_done(10'h050);
      apply_cmd(2'b11, 10'h2AA, 8'd4, hs_a);
      check_output("rsv_no_strobe", {pim_load, mov_load, update_load, elem_valid}, 0);
      check_output("rsv_busy", busy, 1);
      step();
      check_done(10'h050);

      // 5) Abort while stalled after 3 elements.
      apply_cmd(2'b00, 10'h200, 8'd10, hs_a);
      abort = 1'b1;
      #1;
      check_output("abort_ignored_in_load", pim_load, 1);
      abort = 1'b0;
      step();
      run_elems(10'h200, 3);
      array_stall = 1'b1;
      abort       = 1'b1;
      #1;
      check_output("abort_elem", elem_valid, 0);
      check_output("abort_update", update_load, 0);
      step();
      array_stall = 1'b0;
      abort       = 1'b0;
      check_done(10'h203);

      // 6) Asynchronous reset mid-STEP, then a fresh command.
      apply_cmd(2'b00, 10'h0F0, 8'd8, hs_a);
      step();
      run_elems(10'h0F0, 2);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("async_rst_strobes", {pim_load, mov_load, update_load, elem_valid, done}, 0);
      check_output("async_rst_busy", busy, 0);
      check_output("async_rst_ready", cmd_ready, 0);
      check_output("async_rst_addr", cur_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_output("rerelease_ready_low", cmd_ready, 0);
      step();
      check_output("rerelease_ready", cmd_ready, 1);
      apply_cmd(2'b00, 10'h3FF, 8'd2, hs_a);
      check_output("fresh_src_d", src_d, 10'h3FF);
      step();
      elem_cnt = 0;
      run_elems(10'h3FF, 2);
      check_output("fresh_elem_count", elem_cnt, 2);
      check_done(10'h001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
